// File: rtl/half_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder_pkg : shared defaults and counter saturation helper.      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package half_adder_pkg;

  localparam int HA_WIDTH_DEF = 1;
  localparam int HA_CNT_W_DEF = 8;

  // Returns {cnt_w{1'b1}} in a 32-bit container; callers cast to their width.
  function automatic logic [31:0] HA_CNT_MAX(input int cnt_w);
    if (cnt_w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage : half_adder_pkg
`default_nettype wire

// File: rtl/half_adder_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder_cell : 1-bit combinational half adder (s = a^b, c = a&b). |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_cell
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | half_adder : registered lane-parallel half adder, saturating carry   |
// | event counter. Revision 1.0                                          |
// +----------------------------------------------------------------------+
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH_DEF,
  parameter int CNT_W = HA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] cy,
  output logic [CNT_W-1:0] cy_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(HA_CNT_MAX(CNT_W));

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_c;
  logic             w_any_cy;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_cy;
  logic [CNT_W-1:0] r_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (A[i]),
      .b (B[i]),
      .s (w_s[i]),
      .c (w_c[i])
    );
  end

  assign w_any_cy = |w_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
      r_cy  <= '0;
      r_cnt <= '0;
    end else begin
      r_out <= w_s;
      r_cy  <= w_c;
      // Count on the same edge the carry is registered; hold once saturated.
      if (w_any_cy && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out    = r_out;
  assign cy     = r_cy;
  assign cy_cnt = r_cnt;

endmodule : half_adder
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_half_adder : directed and random checks of half_adder variants.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=1, CNT_W=8
  logic       rst_n1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] out1, cy1;
  logic [7:0] cnt1;

  // WIDTH=4, CNT_W=8
  logic       rst_n4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] out4, cy4;
  logic [7:0] cnt4;

  // WIDTH=1, CNT_W=2
  logic       rst_ns = 1'b0;
  logic [0:0] as_ = '0, bs_ = '0;
  logic [0:0] outs, cys;
  logic [1:0] cnts;

  // WIDTH=8, CNT_W=8
  logic       rst_n8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] out8, cy8;
  logic [7:0] cnt8;

  half_adder #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n1), .A(a1), .B(b1), .out(out1), .cy(cy1), .cy_cnt(cnt1)
  );
  half_adder #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst_n(rst_n4), .A(a4), .B(b4), .out(out4), .cy(cy4), .cy_cnt(cnt4)
  );
  half_adder #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_ns), .A(as_), .B(bs_), .out(outs), .cy(cys), .cy_cnt(cnts)
  );
  half_adder #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n8), .A(a8), .B(b8), .out(out8), .cy(cy8), .cy_cnt(cnt8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic a; logic b; logic e_out; logic e_cy; logic [7:0] e_cnt; } vec1_t;
  vec1_t seq1[4] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0},
    '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1}
  };

  logic [1:0] sat_exp[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    #1;
    // ---------------- WIDTH=1 basic sequence ----------------
    step(); step();
    check("w1_rst_out", 32'(out1), 32'd0);
    check("w1_rst_cy",  32'(cy1),  32'd0);
    check("w1_rst_cnt", 32'(cnt1), 32'd0);
    rst_n1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = seq1[i].a; b1 = seq1[i].b;
      step();
      check($sformatf("w1_seq%0d_out", i), 32'(out1), 32'(seq1[i].e_out));
      check($sformatf("w1_seq%0d_cy",  i), 32'(cy1),  32'(seq1[i].e_cy));
      check($sformatf("w1_seq%0d_cnt", i), 32'(cnt1), 32'(seq1[i].e_cnt));
    end

    // ---------------- reset held with A=B=1 ----------------
    rst_n1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("w1_hold%0d_out", i), 32'(out1), 32'd0);
      check($sformatf("w1_hold%0d_cy",  i), 32'(cy1),  32'd0);
      check($sformatf("w1_hold%0d_cnt", i), 32'(cnt1), 32'd0);
    end
    rst_n1 = 1'b1;
    step();
    check("w1_rel_out", 32'(out1), 32'd0);
    check("w1_rel_cy",  32'(cy1),  32'd1);
    check("w1_rel_cnt", 32'(cnt1), 32'd1);

    // Pulse between edges must be ignored.
    rst_n1 = 1'b0; #2; rst_n1 = 1'b1;
    step();
    check("w1_glitch_cnt", 32'(cnt1), 32'd2);
    check("w1_glitch_cy",  32'(cy1),  32'd1);
    for (int i = 0; i < 3; i++) step();
    check("w1_cnt5", 32'(cnt1), 32'd5);

    // ---------------- mid-stream reset ----------------
    rst_n1 = 1'b0;
    step();
    check("w1_mid_out", 32'(out1), 32'd0);
    check("w1_mid_cy",  32'(cy1),  32'd0);
    check("w1_mid_cnt", 32'(cnt1), 32'd0);
    rst_n1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    step();
    check("w1_resume_out", 32'(out1), 32'd1);
    check("w1_resume_cy",  32'(cy1),  32'd0);
    check("w1_resume_cnt", 32'(cnt1), 32'd0);
    a1 = 1'b1; b1 = 1'b1;
    step();
    check("w1_resume2_cnt", 32'(cnt1), 32'd1);

    // ---------------- WIDTH=4 ----------------
    rst_n4 = 1'b1;
    a4 = 4'b1100; b4 = 4'b1010;
    step();
    check("w4_out", 32'(out4), 32'b0110);
    check("w4_cy",  32'(cy4),  32'b1000);
    check("w4_cnt", 32'(cnt4), 32'd1);
    a4 = 4'b1111; b4 = 4'b0000;
    step();
    check("w4_nocy_out", 32'(out4), 32'b1111);
    check("w4_nocy_cy",  32'(cy4),  32'b0000);
    check("w4_nocy_cnt", 32'(cnt4), 32'd1);
    a4 = 4'b0111; b4 = 4'b0101;
    step();
    check("w4_multi_out", 32'(out4), 32'b0010);
    check("w4_multi_cy",  32'(cy4),  32'b0101);
    check("w4_multi_cnt", 32'(cnt4), 32'd2);

    // ---------------- saturation, CNT_W=2 ----------------
    rst_ns = 1'b1; as_ = 1'b1; bs_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("sat%0d_cnt", i), 32'(cnts), 32'(sat_exp[i]));
    end
    as_ = 1'b0;
    step();
    check("sat_idle_cnt", 32'(cnts), 32'd3);
    check("sat_idle_out", 32'(outs), 32'd1);

    // ---------------- random, WIDTH=8 ----------------
    rst_n8 = 1'b1;
    begin
      logic [7:0] e_out, e_cy, e_cnt;
      logic [1:0] lane_sum;
      e_cnt = 8'd0;
      for (int n = 0; n < 1000; n++) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
          lane_sum = 2'(a8[i]) + 2'(b8[i]);
          e_out[i] = lane_sum[0];
          e_cy[i]  = lane_sum[1];
        end
        if ((e_cy != 8'd0) && (e_cnt != 8'd255)) e_cnt = e_cnt + 8'd1;
        step();
        check($sformatf("w8_rnd%0d_out", n), 32'(out8), 32'(e_out));
        check($sformatf("w8_rnd%0d_cy",  n), 32'(cy8),  32'(e_cy));
        check($sformatf("w8_rnd%0d_cnt", n), 32'(cnt8), 32'(e_cnt));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_half_adder
`default_nettype wire
